// File: rtl/mem4x4_arbiter.sv
// rtl/mem4x4_arbiter.sv - two-requester round-robin arbiter/sequencer for a 4x4 scratch memory
// Optional build macro: MEMARB_STATS_EN adds saturating per-requester completion counters cnt0/cnt1.
module mem4x4_arbiter #(
  parameter int AW = 2,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
`ifdef MEMARB_STATS_EN
  ,
  output logic [7:0]    cnt0,
  output logic [7:0]    cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          owner_q, owner_d;
  logic          is_write_q, is_write_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          grant1;
`ifdef MEMARB_STATS_EN
  logic [7:0]    cnt0_q, cnt0_d;
  logic [7:0]    cnt1_q, cnt1_d;
`endif

  // State register: everything clears immediately on reset, dropping any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      is_write_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
`ifdef MEMARB_STATS_EN
      cnt0_q     <= 8'd0;
      cnt1_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      is_write_q <= is_write_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
`ifdef MEMARB_STATS_EN
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
`endif
    end
  end

  // Next-state logic: arbitrate in IDLE, then walk the access through issue/capture/done.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    is_write_d = is_write_q;
    ack0_d     = ack0_q;
    ack1_d     = ack1_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_en_d   = mem_en_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    grant1     = 1'b0;
`ifdef MEMARB_STATS_EN
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Under contention the priority bit picks; otherwise the lone requester wins.
          grant1     = (req0 && req1) ? prio_q : req1;
          owner_d    = grant1;
          is_write_d = grant1 ? we1 : we0;
          mem_en_d   = 1'b1;
          mem_we_d   = grant1 ? we1 : we0;
          mem_addr_d = grant1 ? addr1 : addr0;
          mem_din_d  = grant1 ? wdata1 : wdata0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The access happens at this edge; address and data stay put afterwards.
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (is_write_q) begin
          if (owner_q) ack1_d = 1'b1;
          else         ack0_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (owner_q) begin
          rdata1_d = mem_dout;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = mem_dout;
          ack0_d   = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        // Priority always moves to the non-owner, even when it was not competing.
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        prio_d  = ~owner_q;
`ifdef MEMARB_STATS_EN
        if (owner_q) begin
          if (cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
        end else begin
          if (cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
        end
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign busy     = (state_q != S_IDLE);
`ifdef MEMARB_STATS_EN
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;
`endif

endmodule
